// File: rtl/soc_system_pio_pulse_ctrl.sv
// Avalon-MM PIO with a DATA register, bit set/clear aliases and a timed pulse
// overlay that ORs a mask onto the pins for PULSE_CYCLES clocks.
module soc_system_pio_pulse_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PULSE_CYCLES = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic                  read_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  busy
);

    localparam int unsigned CntW = $clog2(PULSE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(PULSE_CYCLES - 1);

    typedef enum logic {StIdle, StPulse} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [31:0]           readdata_q, readdata_d;

    logic                  wr_en, rd_en, pulse_wr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [31:0]           pulse_rd;
    logic                  unused_wdata;

    assign wr_en    = chipselect & ~write_n;
    assign rd_en    = chipselect & ~read_n;
    assign wdata    = writedata[DATA_WIDTH-1:0];
    assign pulse_wr = wr_en && (address == 2'd3);

    // Bits of writedata above DATA_WIDTH are ignored by design.
    assign unused_wdata = ^writedata;

    always_comb begin
        data_d = data_q;
        if (wr_en) begin
            unique case (address)
                2'd0:    data_d = wdata;
                2'd1:    data_d = data_q | wdata;
                2'd2:    data_d = data_q & ~wdata;
                default: data_d = data_q;
            endcase
        end
    end

    // A pulse write always wins over expiry, so a write in the last cycle retriggers.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (pulse_wr && (wdata != '0)) begin
                    state_d = StPulse;
                    mask_d  = wdata;
                    cnt_d   = CntLoad;
                end
            end
            StPulse: begin
                if (pulse_wr) begin
                    mask_d = mask_q | wdata;
                    cnt_d  = CntLoad;
                end else if (cnt_q == '0) begin
                    state_d = StIdle;
                    mask_d  = '0;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pulse_rd     = 32'(mask_q);
        pulse_rd[31] = pulse_rd[31] | (state_q == StPulse);
        readdata_d   = readdata_q;
        if (rd_en) begin
            if (address == 2'd3) readdata_d = pulse_rd;
            else                 readdata_d = 32'(data_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            data_q     <= RESET_VALUE;
            mask_q     <= '0;
            cnt_q      <= '0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            mask_q     <= mask_d;
            cnt_q      <= cnt_d;
            readdata_q <= readdata_d;
        end
    end

    assign busy     = (state_q == StPulse);
    assign out_port = data_q | (busy ? mask_q : '0);
    assign readdata = readdata_q;

endmodule

// File: tb/tb_soc_system_pio_pulse_ctrl.sv
// Directed bench: an 8-bit/16-cycle instance and a 1-bit/1-cycle instance.
module tb_soc_system_pio_pulse_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect, write_n, read_n;
    logic [31:0] writedata, readdata;
    logic [7:0]  out_port;
    logic        busy;

    logic [1:0]  b_address;
    logic        b_chipselect, b_write_n, b_read_n;
    logic [31:0] b_writedata, b_readdata;
    logic [0:0]  b_out_port;
    logic        b_busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    soc_system_pio_pulse_ctrl #(
        .DATA_WIDTH  (8),
        .PULSE_CYCLES(16),
        .RESET_VALUE (8'h5A)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .read_n    (read_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port),
        .busy      (busy)
    );

    soc_system_pio_pulse_ctrl #(
        .DATA_WIDTH  (1),
        .PULSE_CYCLES(1),
        .RESET_VALUE (1'b0)
    ) u_dut_b (
        .clk       (clk),
        .reset     (reset),
        .address   (b_address),
        .chipselect(b_chipselect),
        .write_n   (b_write_n),
        .read_n    (b_read_n),
        .writedata (b_writedata),
        .readdata  (b_readdata),
        .out_port  (b_out_port),
        .busy      (b_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Bus tasks start and end on a falling edge.
    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        read_n     = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        read_n     = 1'b1;
        d          = readdata;
    endtask

    task automatic count_hi(input int n, input logic [7:0] m, output int c, output int cb);
        c  = 0;
        cb = 0;
        for (int i = 0; i < n; i++) begin
            if ((out_port & m) == m) c++;
            if (busy) cb++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        int c, cb;

        reset        = 1'b1;
        address      = '0;
        chipselect   = 1'b0;
        write_n      = 1'b1;
        read_n       = 1'b1;
        writedata    = '0;
        b_address    = '0;
        b_chipselect = 1'b0;
        b_write_n    = 1'b1;
        b_read_n     = 1'b1;
        b_writedata  = '0;

        repeat (2) @(negedge clk);
        check_eq("rst_out", 32'(out_port), 32'h5A);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_rdata", readdata, 32'h0);
        check_eq("rst_b_out", 32'(b_out_port), 32'h0);
        reset = 1'b0;

        // Data / set / clear
        bus_wr(2'd0, 32'h0000_00A5);
        check_eq("data_wr", 32'(out_port), 32'hA5);
        bus_wr(2'd1, 32'h0000_000A);
        check_eq("set_wr", 32'(out_port), 32'hAF);
        bus_wr(2'd2, 32'h0000_0081);
        check_eq("clr_wr", 32'(out_port), 32'h2E);
        bus_rd(2'd0, rd);
        check_eq("rd_data", rd, 32'h0000_002E);
        bus_rd(2'd1, rd);
        check_eq("rd_set_alias", rd, 32'h0000_002E);
        check_eq("data_no_busy", 32'(busy), 32'h0);

        // Zero-mask pulse write is ignored
        bus_wr(2'd3, 32'h0);
        check_eq("zero_pulse_busy", 32'(busy), 32'h0);
        check_eq("zero_pulse_out", 32'(out_port), 32'h2E);

        // Single pulse, 16 cycles
        bus_wr(2'd0, 32'h0);
        bus_wr(2'd3, 32'h1);
        count_hi(20, 8'h01, c, cb);
        check_eq("pulse_len", 32'(c), 32'd16);
        check_eq("busy_len", 32'(cb), 32'd16);
        check_eq("pulse_end_out", 32'(out_port), 32'h0);

        // Retrigger eight cycles after the first write
        bus_wr(2'd3, 32'h1);
        repeat (7) @(negedge clk);
        bus_wr(2'd3, 32'h2);
        check_eq("retrig_out", 32'(out_port), 32'h03);
        bus_rd(2'd3, rd);
        check_eq("retrig_rd", rd, 32'h8000_0003);
        count_hi(20, 8'h03, c, cb);
        check_eq("retrig_len", 32'(c), 32'd15);
        check_eq("retrig_end", 32'(out_port), 32'h0);

        // Retrigger on the expiry edge keeps the pulse alive
        bus_wr(2'd3, 32'h4);
        count_hi(15, 8'h04, c, cb);
        check_eq("exp_first", 32'(c), 32'd15);
        bus_wr(2'd3, 32'h8);
        check_eq("exp_out", 32'(out_port), 32'h0C);
        count_hi(20, 8'h0C, c, cb);
        check_eq("exp_len", 32'(c), 32'd16);
        check_eq("exp_busy_len", 32'(cb), 32'd16);

        // Asynchronous reset mid-pulse
        bus_wr(2'd3, 32'h1);
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_eq("arst_out", 32'(out_port), 32'h5A);
        check_eq("arst_busy", 32'(busy), 32'h0);
        check_eq("arst_rdata", readdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        bus_wr(2'd0, 32'h3C);
        check_eq("first_wr", 32'(out_port), 32'h3C);
        bus_rd(2'd3, rd);
        check_eq("arst_rd3", rd, 32'h0);

        // Read and write in the same cycle returns the old value
        address    = 2'd0;
        writedata  = 32'h55;
        chipselect = 1'b1;
        write_n    = 1'b0;
        read_n     = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        read_n     = 1'b1;
        check_eq("rw_same_rd", readdata, 32'h3C);
        check_eq("rw_same_out", 32'(out_port), 32'h55);

        // 1-bit, 1-cycle instance
        b_address    = 2'd3;
        b_writedata  = 32'hFFFF_FFFF;
        b_chipselect = 1'b1;
        b_write_n    = 1'b0;
        @(negedge clk);
        b_write_n    = 1'b1;
        b_read_n     = 1'b0;
        check_eq("b_pulse_on", 32'(b_out_port), 32'h1);
        check_eq("b_busy_on", 32'(b_busy), 32'h1);
        @(negedge clk);
        b_chipselect = 1'b0;
        b_read_n     = 1'b1;
        check_eq("b_rd3", b_readdata, 32'h8000_0001);
        check_eq("b_pulse_off", 32'(b_out_port), 32'h0);
        check_eq("b_busy_off", 32'(b_busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
